clock_time_controller: RTL and testbench

Sequencing controller for the doomsday-clock time datapath. It owns the four-digit BCD time register (MM:SS) that feeds the seven-segment and VGA number drawers. It generates the seconds tick and debounces the two front-panel buttons. Based on `mode`, it runs, sets, counts down, or holds the time, and raises `alarm` when a countdown expires.

---
 rtl/clock_time_controller.sv | 182 ++++++++++++++++++
 tb/tb_clock_time_controller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_controller.sv
// MM:SS time sequencer: seconds tick, button debounce, and run/set/countdown/hold control.
// state       | meaning
// ST_RUN      | time counts up on each tick
// ST_SET      | buttons step minutes / seconds
// ST_COUNTDOWN| time counts down on each tick
// ST_HOLD     | time frozen, seconds button clears
// ST_EXPIRED  | countdown reached 00:00, alarm raised
module clock_time_controller #(
    parameter int TICK_DIV        = 100000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic [1:0]  buttonsInput,
    output logic [15:0] big_bin,
    output logic        alarm,
    output logic        tick,
    output logic        setting
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_SET       = 3'd1,
        ST_COUNTDOWN = 3'd2,
        ST_HOLD      = 3'd3,
        ST_EXPIRED   = 3'd4
    } state_t;

    state_t state, next_state;
    logic [1:0]         mode_s1, mode_s2, mode_q;
    logic [1:0]         btn_s1, btn_s2, db_level, press;
    logic [1:0][DW-1:0] db_cnt;
    logic [TW-1:0]      tick_cnt;
    logic [15:0]        time_next;
    logic               time_zero, mode_changed;

    function automatic logic [7:0] inc60(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    function automatic logic [7:0] dec60(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v[3:0] == 4'd0) begin
            r[3:0] = 4'd9;
            r[7:4] = (v[7:4] == 4'd0) ? 4'd5 : v[7:4] - 4'd1;
        end else begin
            r[3:0] = v[3:0] - 4'd1;
        end
        return r;
    endfunction

    function automatic state_t mode_state(input logic [1:0] m);
        state_t s;
        case (m)
            2'b00:   s = ST_RUN;
            2'b01:   s = ST_SET;
            2'b10:   s = ST_COUNTDOWN;
            default: s = ST_HOLD;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_s1 <= '0;
            mode_s2 <= '0;
            mode_q  <= '0;
            btn_s1  <= '0;
            btn_s2  <= '0;
        end else begin
            mode_s1 <= mode;
            mode_s2 <= mode_s1;
            mode_q  <= mode_s2;
            btn_s1  <= buttonsInput;
            btn_s2  <= btn_s1;
        end
    end

    // Counter runs only while the synchronized sample disagrees with the accepted level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt   <= '0;
            db_level <= '0;
            press    <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (btn_s2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i]   <= '0;
                    db_level[i] <= btn_s2[i];
                    press[i]    <= btn_s2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign time_zero    = (big_bin == 16'h0000);
    assign mode_changed = (mode_s2 != mode_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_RUN;
        else      state <= next_state;
    end

    always_comb begin
        next_state = mode_state(mode_s2);
        case (state)
            ST_COUNTDOWN: if (time_zero && mode_s2 == 2'b10) next_state = ST_EXPIRED;
            ST_EXPIRED:   if (press == 2'b00 && !mode_changed) next_state = ST_EXPIRED;
            default: ;
        endcase
    end

    // Counter restarts on every state change, so a tick landing on a transition is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
            alarm    <= 1'b0;
            setting  <= 1'b0;
        end else begin
            tick    <= 1'b0;
            alarm   <= (next_state == ST_EXPIRED);
            setting <= (next_state == ST_SET);
            if ((state == ST_RUN || state == ST_COUNTDOWN) && next_state == state) begin
                if (tick_cnt == TICK_LAST) begin
                    tick_cnt <= '0;
                    tick     <= 1'b1;
                end else begin
                    tick_cnt <= tick_cnt + TW'(1);
                end
            end else begin
                tick_cnt <= '0;
            end
        end
    end

    always_comb begin
        time_next = big_bin;
        case (state)
            ST_RUN: if (tick) begin
                time_next[7:0] = inc60(big_bin[7:0]);
                if (big_bin[7:0] == 8'h59) time_next[15:8] = inc60(big_bin[15:8]);
            end
            ST_SET: begin
                if (press[0]) time_next[15:8] = inc60(big_bin[15:8]);
                if (press[1]) time_next[7:0]  = inc60(big_bin[7:0]);
            end
            ST_COUNTDOWN: if (tick && !time_zero) begin
                time_next[7:0] = dec60(big_bin[7:0]);
                if (big_bin[7:0] == 8'h00) time_next[15:8] = dec60(big_bin[15:8]);
            end
            ST_HOLD: if (press[1]) time_next = 16'h0000;
            default: time_next = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) big_bin <= 16'h0000;
        else      big_bin <= time_next;
    end

endmodule

// File: tb/tb_clock_time_controller.sv
// Bench for clock_time_controller: directed scenarios plus random stimulus against a
// seconds-count reference model.
module tb_clock_time_controller;

    localparam int TD = 10;
    localparam int DB = 4;
    localparam int RUN = 0, SET = 1, CD = 2, HOLD = 3, EXP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [1:0]  btn = 2'b00;
    logic [15:0] big_bin;
    logic        alarm, tick, setting;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int            m_secs, m_st, m_age;
    int            m_mode_s1, m_mode_s2, m_mode_prev;
    bit            m_tick, m_alarm, m_setting;
    bit [1:0]      m_lvl, m_press, m_bs1, m_bs2;
    logic [DB-1:0] m_hist [2];
    int            m_nsamp [2];

    always #5 clk = ~clk;

    clock_time_controller #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .mode(mode), .buttonsInput(btn),
        .big_bin(big_bin), .alarm(alarm), .tick(tick), .setting(setting)
    );

    function automatic logic [15:0] to_bcd(input int t);
        int mm, ss;
        mm = t / 60;
        ss = t % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_secs = 0; m_st = RUN; m_age = 0;
        m_mode_s1 = 0; m_mode_s2 = 0; m_mode_prev = 0;
        m_tick = 0; m_alarm = 0; m_setting = 0;
        m_lvl = 0; m_press = 0; m_bs1 = 0; m_bs2 = 0;
        for (int i = 0; i < 2; i++) begin
            m_hist[i] = '0;
            m_nsamp[i] = 0;
        end
    endtask

    task automatic model_edge();
        int ns, nst, mm, ss;
        bit smp;
        ns = m_secs;
        case (m_st)
            RUN:  if (m_tick) ns = (m_secs + 1) % 3600;
            SET: begin
                mm = m_secs / 60;
                ss = m_secs % 60;
                if (m_press[0]) mm = (mm + 1) % 60;
                if (m_press[1]) ss = (ss + 1) % 60;
                ns = mm * 60 + ss;
            end
            CD:   if (m_tick && m_secs > 0) ns = m_secs - 1;
            HOLD: if (m_press[1]) ns = 0;
            default: ns = 0;
        endcase
        if (m_st == EXP)
            nst = (m_press != 0 || m_mode_s2 != m_mode_prev) ? m_mode_s2 : EXP;
        else if (m_st == CD && m_secs == 0 && m_mode_s2 == CD)
            nst = EXP;
        else
            nst = m_mode_s2;
        if (nst != m_st) begin
            m_age = 0;
            m_tick = 0;
        end else begin
            m_age++;
            m_tick = (m_st == RUN || m_st == CD) && (m_age % TD == 0);
        end
        m_alarm = (nst == EXP);
        m_setting = (nst == SET);
        for (int i = 0; i < 2; i++) begin
            smp = m_bs2[i];
            m_hist[i] = {m_hist[i][DB-2:0], smp};
            if (m_nsamp[i] < DB) m_nsamp[i]++;
            m_press[i] = 0;
            if (m_nsamp[i] == DB && m_hist[i] == {DB{~m_lvl[i]}}) begin
                m_lvl[i] = smp;
                m_press[i] = smp;
            end
        end
        m_mode_prev = m_mode_s2;
        m_mode_s2 = m_mode_s1;
        m_mode_s1 = int'(mode);
        m_bs2 = m_bs1;
        m_bs1 = btn;
        m_secs = ns;
        m_st = nst;
    endtask

    task automatic check_all();
        chk("big_bin", big_bin, to_bcd(m_secs));
        chk("alarm", 16'(alarm), 16'(m_alarm));
        chk("tick", 16'(tick), 16'(m_tick));
        chk("setting", 16'(setting), 16'(m_setting));
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_edge();
        #1;
        check_all();
    endtask

    task automatic async_reset(input int n);
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (n) cyc();
        rst = 1'b1;
    endtask

    task automatic press_btn(input int i, input int hold, input int rel);
        btn[i] = 1'b1;
        repeat (hold) cyc();
        btn[i] = 1'b0;
        repeat (rel) cyc();
    endtask

    task automatic press_n(input int i, input int n);
        repeat (n) press_btn(i, 7, 7);
    endtask

    task automatic set_mode(input int m);
        mode = 2'(m);
        repeat (4) cyc();
    endtask

    task automatic clear_time();
        set_mode(HOLD);
        press_btn(1, 7, 7);
    endtask

    task automatic wait_bcd(input logic [15:0] v, input int max, input string tag);
        int k;
        k = 0;
        while (big_bin !== v && k < max) begin
            cyc();
            k++;
        end
        chk(tag, big_bin, v);
    endtask

    initial begin
        int k;
        model_reset();
        // reset held with toggling inputs
        repeat (8) begin
            mode = 2'($urandom_range(0, 3));
            btn = 2'($urandom_range(0, 3));
            cyc();
            chk("rst_bin", big_bin, 16'h0000);
        end
        mode = 2'b00;
        btn = 2'b00;
        rst = 1'b1;
        repeat (9) cyc();
        chk("pre_tick", 16'(tick), 16'h0000);
        cyc();
        chk("first_tick", 16'(tick), 16'h0001);
        cyc();
        chk("first_inc", big_bin, 16'h0001);

        // rollover
        clear_time();
        chk("cleared", big_bin, 16'h0000);
        set_mode(SET);
        press_n(0, 59);
        press_n(1, 59);
        chk("set_5959", big_bin, 16'h5959);
        set_mode(RUN);
        k = 0;
        while (!tick && k < 25) begin
            cyc();
            k++;
        end
        chk("ro_tick", 16'(tick), 16'h0001);
        cyc();
        chk("rollover", big_bin, 16'h0000);

        // SET seconds wrap without carry, then both buttons at once
        clear_time();
        set_mode(SET);
        press_n(0, 3);
        press_n(1, 60);
        chk("sec_wrap", big_bin, 16'h0300);
        clear_time();
        set_mode(SET);
        btn = 2'b11;
        repeat (7) cyc();
        btn = 2'b00;
        repeat (7) cyc();
        chk("both_btn", big_bin, 16'h0101);

        // debounce
        clear_time();
        set_mode(SET);
        press_btn(0, 3, 10);
        chk("glitch", big_bin, 16'h0000);
        press_btn(0, 6, 8);
        chk("db_press", big_bin, 16'h0100);

        // countdown expiry
        clear_time();
        set_mode(SET);
        press_n(1, 2);
        chk("cd_start", big_bin, 16'h0002);
        mode = 2'(CD);
        wait_bcd(16'h0001, 25, "cd_0001");
        wait_bcd(16'h0000, 25, "cd_0000");
        chk("alarm_pre", 16'(alarm), 16'h0000);
        cyc();
        chk("alarm_rise", 16'(alarm), 16'h0001);
        repeat (5) cyc();
        chk("alarm_hold", 16'(alarm), 16'h0001);
        chk("exp_time", big_bin, 16'h0000);
        btn[1] = 1'b1;
        k = 0;
        while (alarm && k < 12) begin
            cyc();
            k++;
        end
        chk("exp_exit", 16'(alarm), 16'h0000);
        cyc();
        chk("reexpire", 16'(alarm), 16'h0001);
        btn[1] = 1'b0;
        repeat (8) cyc();
        set_mode(HOLD);
        chk("exp_mode_exit", 16'(alarm), 16'h0000);

        // HOLD
        clear_time();
        set_mode(SET);
        press_n(0, 12);
        press_n(1, 34);
        chk("set_1234", big_bin, 16'h1234);
        set_mode(HOLD);
        repeat (50) cyc();
        chk("hold_frozen", big_bin, 16'h1234);
        press_btn(0, 7, 7);
        chk("hold_p0", big_bin, 16'h1234);
        press_btn(1, 7, 7);
        chk("hold_p1", big_bin, 16'h0000);

        // random traffic against the model, with occasional async reset
        repeat (3000) begin
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) begin
                k = $urandom_range(0, 1);
                btn[k] = ~btn[k];
            end
            if ($urandom_range(0, 799) == 0) async_reset(2);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
